// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared types and sizing helpers for the code lock controller
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        OPEN    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    // Smallest width that holds max(open, lockout) - 1, never less than one bit.
    function automatic int timer_width(input int open_cycles, input int lockout_cycles);
        int m;
        int w;
        m = (open_cycles > lockout_cycles) ? open_cycles : lockout_cycles;
        w = 1;
        while ((1 << w) < m) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter with zero flag, shared by OPEN and LOCKOUT
module cycle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/code_lock_ctrl.sv
// rtl/code_lock_ctrl.sv - serial code entry, attempt counting and timed open/lockout
module code_lock_ctrl
    import lock_pkg::*;
#(
    parameter int                  CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] CODE           = 4'b0011,
    parameter int                  MAX_TRIES      = 3,
    parameter int                  OPEN_CYCLES    = 8,
    parameter int                  LOCKOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             bit_valid,
    input  logic                             bit_in,
    input  logic                             clr,
    output logic                             unlock,
    output logic                             locked_out,
    output logic                             fail_pulse,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

    localparam int TW  = timer_width(OPEN_CYCLES, LOCKOUT_CYCLES);
    localparam int CW  = $clog2(CODE_LEN + 1);
    localparam int TRW = $clog2(MAX_TRIES + 1);

    state_t              state_q;
    state_t              state_d;
    logic [CW-1:0]       bit_cnt_q;
    logic [CW-1:0]       bit_cnt_d;
    logic [CODE_LEN-1:0] shift_q;
    logic [CODE_LEN-1:0] shift_d;
    logic [TRW-1:0]      tries_q;
    logic [TRW-1:0]      tries_d;
    logic                fail_q;
    logic                fail_d;

    logic                timer_load;
    logic [TW-1:0]       timer_load_val;
    logic                timer_zero;

    logic                entering;
    logic                accept;
    logic                last_bit;
    logic                last_try;
    logic [CODE_LEN:0]   shift_ext;
    logic [CODE_LEN-1:0] word;
    logic                match;

    // clr outranks bit_valid; OPEN/LOCKOUT ignore both.
    assign entering  = (state_q == IDLE) || (state_q == COLLECT);
    assign accept    = entering && bit_valid && !clr;
    assign last_bit  = accept && (bit_cnt_q == CW'(CODE_LEN - 1));
    assign shift_ext = {shift_q, bit_in};
    assign word      = shift_ext[CODE_LEN-1:0];
    assign match     = (word == CODE);
    assign last_try  = (tries_q == TRW'(1));

    cycle_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_load_val),
        .zero     (timer_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, COLLECT: begin
                if (clr) begin
                    state_d = IDLE;
                end else if (last_bit) begin
                    if (match) begin
                        state_d = OPEN;
                    end else if (last_try) begin
                        state_d = LOCKOUT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    state_d = COLLECT;
                end
            end
            OPEN, LOCKOUT: begin
                if (timer_zero) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        unlock     = (state_q == OPEN);
        locked_out = (state_q == LOCKOUT);
        fail_pulse = fail_q;
        tries_left = tries_q;
    end

    always_comb begin
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        tries_d        = tries_q;
        fail_d         = 1'b0;
        timer_load     = 1'b0;
        timer_load_val = '0;
        if (entering && clr) begin
            bit_cnt_d = '0;
            shift_d   = '0;
        end else if (last_bit) begin
            bit_cnt_d  = '0;
            shift_d    = '0;
            if (match) begin
                tries_d        = TRW'(MAX_TRIES);
                timer_load     = 1'b1;
                timer_load_val = TW'(OPEN_CYCLES - 1);
            end else begin
                tries_d = tries_q - 1'b1;
                fail_d  = 1'b1;
                if (last_try) begin
                    timer_load     = 1'b1;
                    timer_load_val = TW'(LOCKOUT_CYCLES - 1);
                end
            end
        end else if (accept) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = word;
        end
        if ((state_q == LOCKOUT) && timer_zero) begin
            tries_d = TRW'(MAX_TRIES);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tries_q   <= TRW'(MAX_TRIES);
            fail_q    <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tries_q   <= tries_d;
            fail_q    <= fail_d;
        end
    end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb/tb_code_lock_ctrl.sv - table-driven bench for code_lock_ctrl with default parameters
module tb_code_lock_ctrl;

    logic       clk;
    logic       reset;
    logic       bit_valid;
    logic       bit_in;
    logic       clr;
    logic       unlock;
    logic       locked_out;
    logic       fail_pulse;
    logic [1:0] tries_left;

    int n_vec;
    int n_bad;

    typedef struct {
        logic       rst;
        logic       bv;
        logic       bi;
        logic       cl;
        logic       eu;
        logic       el;
        logic       ef;
        logic [1:0] et;
        string      name;
    } vec_t;

    vec_t tbl[$];

    code_lock_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .clr        (clr),
        .unlock     (unlock),
        .locked_out (locked_out),
        .fail_pulse (fail_pulse),
        .tries_left (tries_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic v, input logic b, input logic c,
                       input logic eu, input logic el, input logic ef, input logic [1:0] et,
                       input string name);
        vec_t x;
        x.rst = r; x.bv = v; x.bi = b; x.cl = c;
        x.eu = eu; x.el = el; x.ef = ef; x.et = et; x.name = name;
        tbl.push_back(x);
    endtask

    // Inputs are applied for one edge; outputs are sampled 1 time unit after it.
    task automatic apply(input vec_t x);
        reset = x.rst; bit_valid = x.bv; bit_in = x.bi; clr = x.cl;
        @(posedge clk);
        #1;
        n_vec++;
        if (unlock !== x.eu || locked_out !== x.el || fail_pulse !== x.ef || tries_left !== x.et) begin
            n_bad++;
            $display("FAIL %s (vec %0d): got u=%b l=%b f=%b t=%0d, want u=%b l=%b f=%b t=%0d",
                     x.name, n_vec, unlock, locked_out, fail_pulse, tries_left,
                     x.eu, x.el, x.ef, x.et);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic b, input logic c,
                        input logic eu, input logic el, input logic ef, input logic [1:0] et,
                        input string name);
        vec_t x;
        x.rst = r; x.bv = v; x.bi = b; x.cl = c;
        x.eu = eu; x.el = el; x.ef = ef; x.et = et; x.name = name;
        apply(x);
    endtask

    // Four bits entered back to back; only the last row's outcome differs.
    task automatic add_code(input logic [3:0] code, input logic [1:0] t_before,
                            input logic eu, input logic el, input logic ef, input logic [1:0] t_after,
                            input string name);
        for (int i = 3; i >= 1; i--) begin
            add(0, 1, code[i], 0, 0, 0, 0, t_before, name);
        end
        add(0, 1, code[0], 0, eu, el, ef, t_after, name);
    endtask

    task automatic add_open_tail(input string name);
        for (int i = 0; i < 7; i++) begin
            add(0, 1, i[0], (i == 3), 1, 0, 0, 3, name);
        end
        add(0, 0, 0, 0, 0, 0, 0, 3, {name, "_close"});
    endtask

    initial begin
        logic [3:0] good;
        logic [3:0] wrong;
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; clr = 1'b0;
        good  = 4'b0011;
        wrong = 4'b1011;

        add(1, 0, 0, 0, 0, 0, 0, 3, "reset");
        add(1, 1, 1, 0, 0, 0, 0, 3, "reset");

        add_code(good, 3, 1, 0, 0, 3, "correct");
        add_open_tail("correct_open");
        add_code(good, 3, 1, 0, 0, 3, "reopen");
        add_open_tail("reopen_open");

        add_code(wrong, 3, 0, 0, 1, 2, "wrong1");
        add(0, 0, 0, 0, 0, 0, 0, 2, "fail_one_cycle");
        for (int i = 3; i >= 0; i--) begin
            for (int g = 0; g < 3; g++) begin
                add(0, 0, 1, 0, 0, 0, 0, 2, "gap");
            end
            add(0, 1, good[i], 0, (i == 0), 0, 0, (i == 0) ? 2'd3 : 2'd2, "gapped_code");
        end
        add_open_tail("gapped_open");

        add_code(4'b1111, 3, 0, 0, 1, 2, "lock_w1");
        add_code(4'b0000, 2, 0, 0, 1, 1, "lock_w2");
        add_code(4'b0111, 1, 0, 1, 1, 0, "lock_w3");
        for (int i = 0; i < 15; i++) begin
            add(0, (i < 4), (i >= 2), 0, 0, 1, 0, 0, "lockout_window");
        end
        add(0, 0, 0, 0, 0, 0, 0, 3, "lockout_exit");
        add_code(good, 3, 1, 0, 0, 3, "after_lockout");
        add_open_tail("after_lockout_open");

        add(0, 1, 1, 0, 0, 0, 0, 3, "partial");
        add(0, 1, 1, 0, 0, 0, 0, 3, "partial");
        add(0, 1, 0, 1, 0, 0, 0, 3, "clr_with_bit");
        add_code(good, 3, 1, 0, 0, 3, "after_clr");
        add_open_tail("after_clr_open");
        add(0, 0, 0, 1, 0, 0, 0, 3, "clr_idle");
        add_code(good, 3, 1, 0, 0, 3, "after_idle_clr");
        add_open_tail("after_idle_clr_open");

        foreach (tbl[i]) begin
            apply(tbl[i]);
        end

        // Reset during OPEN, with tries below max beforehand.
        for (int i = 3; i >= 0; i--) begin
            step(0, 1, wrong[i], 0, 0, 0, (i == 0), (i == 0) ? 2'd2 : 2'd3, "pre_open_wrong");
        end
        for (int i = 3; i >= 0; i--) begin
            step(0, 1, good[i], 0, (i == 0), 0, 0, (i == 0) ? 2'd3 : 2'd2, "pre_open_good");
        end
        step(0, 0, 0, 0, 1, 0, 0, 3, "open_c2");
        step(1, 0, 0, 0, 0, 0, 0, 3, "reset_in_open");

        // Reset during LOCKOUT: three wrong codes, then reset in cycle 5.
        for (int k = 0; k < 3; k++) begin
            for (int i = 3; i >= 0; i--) begin
                step(0, 1, 1'b1, 0, 0, (k == 2) && (i == 0), (i == 0),
                     (i == 0) ? 2'(2 - k) : 2'(3 - k), "mid_lock_wrong");
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 1, 0, 0, "mid_lock_wait");
        end
        step(1, 0, 0, 0, 0, 0, 0, 3, "reset_in_lockout");
        for (int i = 3; i >= 0; i--) begin
            step(0, 1, good[i], 0, (i == 0), 0, 0, 3, "open_after_reset");
        end
        step(0, 0, 0, 0, 1, 0, 0, 3, "open_after_reset_c2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
